// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encoding, FSM states and op decode helpers
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MADD  = 3'b100,
        OP_MADDU = 3'b101,
        OP_MTHI  = 3'b110,
        OP_MTLO  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD);
    endfunction

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic op_is_mt(input op_e op);
        return (op == OP_MTHI) || (op == OP_MTLO);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - EX-stage request/result bundle of the multiply/divide unit
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] dataA;
    logic [WIDTH-1:0] dataB;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, dataA, dataB, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, dataA, dataB, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - one radix-2 shift-add or restoring-divide step
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   prod,
    input  logic [WIDTH-1:0]     opnd,
    output logic [2*WIDTH-1:0]   prod_nxt
);

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] rem_sub;

    // Upper half holds partial product / remainder, lower half multiplier / quotient.
    always_comb begin
        add_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
        shifted  = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
        fits     = (shifted >= {1'b0, opnd});
        // A successful subtraction always leaves a value below the divisor, so W bits suffice.
        rem_sub  = shifted[WIDTH-1:0] - opnd;
        prod_nxt = {add_sum, prod[WIDTH-1:1]};
        if (is_div) begin
            if (fits) begin
                prod_nxt = {rem_sub, prod[WIDTH-2:0], 1'b1};
            end else begin
                prod_nxt = {shifted[WIDTH-1:0], prod[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle signed/unsigned multiply, divide, MADD with HI/LO
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic    clk,
    input  logic    reset,
    muldiv_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int W2 = 2 * WIDTH;

    state_e           state, state_nxt;
    op_e              op_in, op_q;
    logic [W2-1:0]    prod, prod_nxt, snap, result, prod_s;
    logic [WIDTH-1:0] opnd, a_raw, hi_q, lo_q;
    logic [WIDTH-1:0] a_mag, b_mag, quo_s, rem_s;
    logic             a_neg, b_neg, neg_res, neg_rem;
    logic [CW-1:0]    cnt;
    logic             busy_q, done_q;
    logic             accept, load, step, commit, wr_hi, wr_lo;

    assign op_in   = op_e'(bus.op);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept && !op_is_mt(op_in)) state_nxt = S_CALC;
            S_CALC: begin
                if (bus.flush) begin
                    state_nxt = S_IDLE;
                end else if (cnt == CW'(WIDTH - 1)) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // A flush in IDLE suppresses a simultaneous start, including MTHI/MTLO.
    always_comb begin
        accept = (state == S_IDLE) && bus.start && !bus.flush;
        load   = accept && !op_is_mt(op_in);
        wr_hi  = accept && (op_in == OP_MTHI);
        wr_lo  = accept && (op_in == OP_MTLO);
        step   = (state == S_CALC) && !bus.flush;
        commit = (state == S_FIX) && !bus.flush;
    end

    always_comb begin
        a_neg = op_is_signed(op_in) && bus.dataA[WIDTH-1];
        b_neg = op_is_signed(op_in) && bus.dataB[WIDTH-1];
        a_mag = a_neg ? -bus.dataA : bus.dataA;
        b_mag = b_neg ? -bus.dataB : bus.dataB;
    end

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .is_div   (op_is_div(op_q)),
        .prod     (prod),
        .opnd     (opnd),
        .prod_nxt (prod_nxt)
    );

    // Unsigned ops never set the negate flags, so one fix-up path serves both.
    always_comb begin
        prod_s = neg_res ? -prod : prod;
        quo_s  = neg_res ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
        rem_s  = neg_rem ? -prod[W2-1:WIDTH] : prod[W2-1:WIDTH];
        case (op_q)
            OP_MADD, OP_MADDU: result = snap + prod_s;
            OP_DIV, OP_DIVU:   result = (opnd == '0) ? {a_raw, {WIDTH{1'b1}}}
                                                     : {rem_s, quo_s};
            default:           result = prod_s;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q    <= OP_MULT;
            prod    <= '0;
            snap    <= '0;
            opnd    <= '0;
            a_raw   <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            cnt     <= '0;
        end else if (load) begin
            op_q    <= op_in;
            prod    <= {{WIDTH{1'b0}}, op_is_div(op_in) ? a_mag : b_mag};
            opnd    <= op_is_div(op_in) ? b_mag : a_mag;
            snap    <= {hi_q, lo_q};
            a_raw   <= bus.dataA;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            cnt     <= '0;
        end else if (step) begin
            prod    <= prod_nxt;
            cnt     <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_nxt != S_IDLE);
            done_q <= commit;
            if (wr_hi) hi_q <= bus.dataA;
            if (wr_lo) lo_q <= bus.dataA;
            if (commit) begin
                hi_q <= result[W2-1:WIDTH];
                lo_q <= result[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized and directed checks of muldiv_unit against an arithmetic model
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(32)) bus32 ();
    muldiv_if #(.WIDTH(8))  bus8 ();

    muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));
    muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8.slave));

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [63:0] exp_hilo = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    function automatic logic [63:0] ref_op(input op_e op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] hilo);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, uq, ur, res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        res = hilo;
        case (op)
            OP_MULT:  res = sa * sb;
            OP_MULTU: res = ua * ub;
            OP_MADD:  res = hilo + sa * sb;
            OP_MADDU: res = hilo + ua * ub;
            OP_DIV: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            OP_DIVU: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else begin
                    uq = ua / ub;
                    ur = ua % ub;
                    res = {ur[31:0], uq[31:0]};
                end
            end
            OP_MTHI:  res = {a, hilo[31:0]};
            OP_MTLO:  res = {hilo[63:32], a};
            default:  res = hilo;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // Called and returning at a negedge; the next call's start lands in the done cycle.
    task automatic run32(input op_e op, input logic [31:0] a, input logic [31:0] b, input bit noise);
        logic [63:0] want;
        want = ref_op(op, a, b, exp_hilo);
        bus32.start = 1'b1;
        bus32.op    = op;
        bus32.dataA = a;
        bus32.dataB = b;
        @(posedge clk);
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (k == 1) bus32.start = 1'b0;
            if (noise && (k == 5 || k == 33)) begin
                bus32.start = 1'b1;
                bus32.op    = OP_MTHI;
                bus32.dataA = $urandom;
                bus32.dataB = $urandom;
            end
            if (noise && (k == 6 || k == 34)) bus32.start = 1'b0;
            chk("busy", {63'b0, bus32.busy}, {63'b0, k <= 33});
            chk("done", {63'b0, bus32.done}, {63'b0, k == 34});
            if (k == 33) chk("hilo_hold", {bus32.hi, bus32.lo}, exp_hilo);
        end
        chk("hi", {32'b0, bus32.hi}, {32'b0, want[63:32]});
        chk("lo", {32'b0, bus32.lo}, {32'b0, want[31:0]});
        exp_hilo = want;
    endtask

    task automatic run_mt(input op_e op, input logic [31:0] a);
        bus32.start = 1'b1;
        bus32.op    = op;
        bus32.dataA = a;
        @(posedge clk);
        @(negedge clk);
        bus32.start = 1'b0;
        exp_hilo = ref_op(op, a, 32'h0, exp_hilo);
        chk("mt_hilo", {bus32.hi, bus32.lo}, exp_hilo);
        chk("mt_busy", {63'b0, bus32.busy}, 64'd0);
        chk("mt_done", {63'b0, bus32.done}, 64'd0);
    endtask

    task automatic run8(input op_e op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] want_hi, input logic [7:0] want_lo);
        bus8.start = 1'b1;
        bus8.op    = op;
        bus8.dataA = a;
        bus8.dataB = b;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) bus8.start = 1'b0;
            chk("w8_busy", {63'b0, bus8.busy}, {63'b0, k <= 9});
            chk("w8_done", {63'b0, bus8.done}, {63'b0, k == 10});
        end
        chk("w8_hi", {56'b0, bus8.hi}, {56'b0, want_hi});
        chk("w8_lo", {56'b0, bus8.lo}, {56'b0, want_lo});
    endtask

    initial begin
        logic [31:0] ra, rb;
        op_e         rop;
        bit          seen;

        reset = 1'b1;
        bus32.start = 1'b0; bus32.op = 3'b0; bus32.dataA = '0; bus32.dataB = '0; bus32.flush = 1'b0;
        bus8.start  = 1'b0; bus8.op  = 3'b0; bus8.dataA  = '0; bus8.dataB  = '0; bus8.flush  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {63'b0, bus32.busy}, 64'd0);
        chk("rst_done", {63'b0, bus32.done}, 64'd0);
        chk("rst_hilo", {bus32.hi, bus32.lo}, 64'd0);
        chk("rst8_out", {46'b0, bus8.busy, bus8.done, bus8.hi, bus8.lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run32(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_mt(OP_MTHI, 32'h0000_0000);
        run_mt(OP_MTLO, 32'hFFFF_FFFF);
        run32(OP_MADDU, 32'd1, 32'd1, 1'b0);
        run32(OP_MULT, -32'sd3, 32'd5, 1'b0);
        run32(OP_DIV, -32'sd7, 32'd2, 1'b0);
        run32(OP_DIVU, 32'd7, 32'd0, 1'b0);
        run32(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run32(OP_DIV, -32'sd5, 32'd0, 1'b0);
        run32(OP_MADD, -32'sd2, 32'h7FFF_FFFF, 1'b0);
        run32(OP_MULTU, $urandom, $urandom, 1'b1);
        run32(OP_DIVU, $urandom, $urandom_range(1, 1000), 1'b1);

        // flush mid-CALC: abort without touching HI/LO
        bus32.start = 1'b1; bus32.op = OP_MULT; bus32.dataA = 32'd12345; bus32.dataB = 32'd678;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) bus32.start = 1'b0;
            if (k == 10) bus32.flush = 1'b1;
        end
        @(negedge clk);
        bus32.flush = 1'b0;
        chk("flush_busy", {63'b0, bus32.busy}, 64'd0);
        chk("flush_hilo", {bus32.hi, bus32.lo}, exp_hilo);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus32.done || bus32.busy) seen = 1'b1;
        end
        chk("flush_no_done", {63'b0, seen}, 64'd0);

        // flush in IDLE blocks a simultaneous start
        bus32.start = 1'b1; bus32.flush = 1'b1; bus32.op = OP_MTHI; bus32.dataA = 32'h1234_5678;
        @(negedge clk);
        bus32.op = OP_MULTU;
        @(negedge clk);
        bus32.start = 1'b0; bus32.flush = 1'b0;
        chk("idle_flush_hilo", {bus32.hi, bus32.lo}, exp_hilo);
        chk("idle_flush_busy", {63'b0, bus32.busy}, 64'd0);

        // reset at cycle 20 of an op
        run_mt(OP_MTHI, 32'hA5A5_A5A5);
        bus32.start = 1'b1; bus32.op = OP_MULTU; bus32.dataA = 32'hFFFF_FFFF; bus32.dataB = 32'h3;
        @(posedge clk);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) bus32.start = 1'b0;
            if (k == 20) reset = 1'b1;
        end
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_out", {30'b0, bus32.busy, bus32.done, bus32.hi}, 64'd0);
        chk("midrst_lo", {32'b0, bus32.lo}, 64'd0);
        exp_hilo = '0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus32.done || bus32.busy) seen = 1'b1;
        end
        chk("midrst_quiet", {63'b0, seen}, 64'd0);

        for (int n = 0; n < 30; n++) begin
            rop = op_e'($urandom_range(0, 7));
            ra  = pick_operand();
            rb  = pick_operand();
            if (op_is_mt(rop)) run_mt(rop, ra);
            else run32(rop, ra, rb, $urandom_range(0, 3) == 0);
        end

        run8(OP_MULT, 8'h80, 8'h80, 8'h40, 8'h00);
        run8(OP_DIV,  8'h80, 8'hFF, 8'h00, 8'h80);
        run8(OP_DIVU, 8'd200, 8'd7, 8'd4, 8'd28);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
